// File: rtl/spi_pkg.sv
// SPI controller shared definitions.
// Frame layout, register map and FSM state encoding.
package spi_pkg;

   localparam int SPI_FRAME_W   = 16;
   localparam int SPI_ADDR_W    = 7;
   localparam int SPI_DATA_W    = 8;
   localparam int SPI_WRITE_BIT = 15;

   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'd0;
   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'd1;
   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'd2;
   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'd3;
   localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'd4;
   localparam logic [SPI_ADDR_W-1:0] SPI_MAX_ADDRESS  = 7'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

endpackage

// File: rtl/spi_controller_if.sv
// SPI controller host request bus.
// Valid/ready handshake carrying one write/addr/data frame.
interface spi_controller_if;
   import spi_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [SPI_ADDR_W-1:0] req_addr;
   logic [SPI_DATA_W-1:0] req_data;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/spi_sclk_divider.sv
// SCLK half-period tick generator.
// Tick fires on the last clk of each half period while enabled.
module spi_sclk_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Count clk cycles within a half period; restart on tick or when idle
   always_comb begin
      tick_o = en_i && (cnt_q == DIV_M1);
      cnt_d  = 8'd0;
      if (en_i && !tick_o)
         cnt_d = cnt_q + 8'd1;
   end

   // Divider counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame controller.
// Sends one 16-bit {write, addr, data} frame per accepted request.
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic clk,
   input  logic rst_n,
   spi_controller_if.slave req,
   output logic busy,
   output logic done,
   output logic nCS,
   output logic SCLK,
   output logic COPI
);

   localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);

   spi_state_e             state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [4:0]             bit_q, bit_d;
   logic                   phase_q, phase_d;
   logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
   logic                   ncs_q, ncs_d;
   logic                   sclk_q, sclk_d;
   logic                   copi_q, copi_d;
   logic                   done_q, done_d;
   logic                   tick;
   logic                   accept;
   logic                   cs_active;

   assign req.req_ready = (state_q == ST_IDLE);
   assign busy          = !req.req_ready;
   assign accept        = req.req_valid && req.req_ready;
   assign nCS           = ncs_q;
   assign SCLK          = sclk_q;
   assign COPI          = copi_q;
   assign done          = done_q;

   spi_sclk_divider #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (state_q == ST_SHIFT),
      .tick_o(tick)
   );

   // State, counters, shift register and registered pin outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         bit_q   <= 5'd0;
         phase_q <= 1'b0;
         shreg_q <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         shreg_q <= shreg_d;
         ncs_q   <= ncs_d;
         sclk_q  <= sclk_d;
         copi_q  <= copi_d;
         done_q  <= done_d;
      end
   end

   // Next state: phase timing, bit shifting on each high->low boundary
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 8'd1;
      bit_d   = bit_q;
      phase_d = phase_q;
      shreg_d = shreg_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = 8'd0;
            if (accept) begin
               state_d = ST_SETUP;
               shreg_d = {req.req_write, req.req_addr, req.req_data};
               bit_d   = 5'd0;
               phase_d = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_M1) begin
               state_d = ST_SHIFT;
               cnt_d   = 8'd0;
            end
         end
         ST_SHIFT: begin
            cnt_d = 8'd0;
            if (tick) begin
               phase_d = !phase_q;
               if (phase_q) begin
                  shreg_d = {shreg_q[SPI_FRAME_W-2:0], 1'b0};
                  bit_d   = bit_q + 5'd1;
                  if (bit_q == 5'd15)
                     state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_M1) begin
               state_d = ST_GAP;
               cnt_d   = 8'd0;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_M1) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Pin values for the upcoming cycle, derived from next state
   always_comb begin
      cs_active = (state_d == ST_SETUP) ||
                  (state_d == ST_SHIFT) ||
                  (state_d == ST_HOLD);
      ncs_d  = !cs_active;
      sclk_d = (state_d == ST_SHIFT) && phase_d;
      copi_d = cs_active && shreg_d[SPI_FRAME_W-1];
      done_d = (state_q == ST_HOLD) && (state_d == ST_GAP);
   end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller.
// Frame capture on SCLK rises plus a register-file peripheral model.
module tb_spi_controller;
   import spi_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   spi_controller_if bus0();
   spi_controller_if bus1();

   logic busy0, done0, ncs0, sclk0, copi0;
   logic busy1, done1, ncs1, sclk1, copi1;

   spi_controller #(
      .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(bus0),
      .busy(busy0), .done(done0), .nCS(ncs0),
      .SCLK(sclk0), .COPI(copi0)
   );

   spi_controller #(
      .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .req(bus1),
      .busy(busy1), .done(done1), .nCS(ncs1),
      .SCLK(sclk1), .COPI(copi1)
   );

   logic [1:0] ncs, sclk, copi, dn, rdy;
   assign ncs  = {ncs1, ncs0};
   assign sclk = {sclk1, sclk0};
   assign copi = {copi1, copi0};
   assign dn   = {done1, done0};
   assign rdy  = {bus1.req_ready, bus0.req_ready};

   typedef struct {
      int          cnt;
      int          low;
      logic [15:0] fr;
   } rec_t;

   typedef struct {
      logic        w;
      logic [6:0]  a;
      logic [7:0]  d;
      logic [15:0] fr;
   } vec_t;

   rec_t q0[$];
   rec_t q1[$];
   int   gq0[$];
   rec_t mr;

   int total = 0;
   int bad   = 0;

   logic        prev_ncs[2], prev_sclk[2], prev_copi[2];
   logic [15:0] rx[2];
   int          rxc[2], low[2], high[2], done_cnt[2];
   int          rises[2], cviol[2], rviol[2];
   bit          seen[2];
   logic [7:0]  preg[2][5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drv(input int k, input logic v, input logic w,
                      input logic [6:0] a, input logic [7:0] d);
      if (k == 0) begin
         bus0.req_valid = v; bus0.req_write = w;
         bus0.req_addr  = a; bus0.req_data  = d;
      end else begin
         bus1.req_valid = v; bus1.req_write = w;
         bus1.req_addr  = a; bus1.req_data  = d;
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   // Called just after a negedge; one-cycle valid pulse, then junk inputs
   task automatic send_req(input int k, input logic w,
                           input logic [6:0] a, input logic [7:0] d);
      int n = 0;
      while (!rdy[k] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) chk("ready_timeout", 32'd0, 32'd1);
      drv(k, 1'b1, w, a, d);
      @(posedge clk);
      #1;
      drv(k, 1'b0, ~w, ~a, ~d);
   endtask

   task automatic wait_done(input int k, input int tgt, input int budget);
      for (int i = 0; i < budget && done_cnt[k] < tgt; i++)
         @(negedge clk);
      if (done_cnt[k] < tgt) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_frame(input int k, input logic w,
                            input logic [6:0] a, input logic [7:0] d,
                            input logic [15:0] exp_fr, input int exp_low,
                            input string nm);
      int   dc, qs;
      rec_t r;
      dc = done_cnt[k];
      qs = qsize(k);
      send_req(k, w, a, d);
      wait_done(k, dc + 1, 2000);
      repeat (2) @(negedge clk);
      chk({nm, "_done"}, 32'(done_cnt[k] - dc), 32'd1);
      chk({nm, "_nfr"}, 32'(qsize(k) - qs), 32'd1);
      if (qsize(k) > qs) begin
         r = (k == 0) ? q0[$] : q1[$];
         chk({nm, "_frame"}, 32'(r.fr), 32'(exp_fr));
         chk({nm, "_bits"}, 32'(r.cnt), 32'd16);
         chk({nm, "_ncslow"}, 32'(r.low), 32'(exp_low));
      end
   endtask

   // Bus monitor: frame capture, timing counts, peripheral register model
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               seen[k] = 1'b0;
               low[k]  = 0;
               high[k] = 0;
               rxc[k]  = 0;
            end else begin
               if (prev_ncs[k] && !ncs[k]) begin
                  if (seen[k] && k == 0) gq0.push_back(high[k]);
                  rx[k]  = '0;
                  rxc[k] = 0;
                  low[k] = 0;
               end
               if (!ncs[k]) low[k]++;
               if (!prev_sclk[k] && sclk[k] && !ncs[k]) begin
                  rx[k] = {rx[k][14:0], copi[k]};
                  rxc[k]++;
                  rises[k]++;
               end
               if (prev_sclk[k] && sclk[k] && copi[k] !== prev_copi[k])
                  cviol[k]++;
               if (sclk[k] && ncs[k]) cviol[k]++;
               if (!ncs[k] && rdy[k]) rviol[k]++;
               if (!prev_ncs[k] && ncs[k]) begin
                  mr.cnt = rxc[k];
                  mr.low = low[k];
                  mr.fr  = rx[k];
                  if (k == 0) q0.push_back(mr);
                  else        q1.push_back(mr);
                  if (rxc[k] == 16 && rx[k][15] &&
                      rx[k][14:8] <= SPI_MAX_ADDRESS)
                     preg[k][int'(rx[k][14:8])] = rx[k][7:0];
                  high[k] = 0;
                  seen[k] = 1'b1;
               end
               if (ncs[k]) high[k]++;
               if (dn[k]) done_cnt[k]++;
            end
            prev_ncs[k]  = ncs[k];
            prev_sclk[k] = sclk[k];
            prev_copi[k] = copi[k];
         end
      end
   end

   vec_t vt[7];

   initial begin
      int dc, qs, r0;
      logic [31:0] allregs;

      for (int k = 0; k < 2; k++) begin
         prev_ncs[k] = 1'b1; prev_sclk[k] = 1'b0; prev_copi[k] = 1'b0;
         rx[k] = '0; rxc[k] = 0; low[k] = 0; high[k] = 0;
         done_cnt[k] = 0; rises[k] = 0; cviol[k] = 0; rviol[k] = 0;
         seen[k] = 1'b0;
         for (int j = 0; j < 5; j++) preg[k][j] = 8'h00;
      end

      vt[0] = '{1'b1, 7'h00, 8'hA5, 16'h80A5};
      vt[1] = '{1'b1, 7'h01, 8'h3C, 16'h813C};
      vt[2] = '{1'b1, 7'h02, 8'h0F, 16'h820F};
      vt[3] = '{1'b1, 7'h03, 8'hF0, 16'h83F0};
      vt[4] = '{1'b1, 7'h04, 8'h80, 16'h8480};
      vt[5] = '{1'b0, 7'h55, 8'h12, 16'h5512};
      vt[6] = '{1'b0, 7'h7F, 8'h00, 16'h7F00};

      rst_n = 1'b0;
      drv(0, 1'b0, 1'b0, 7'h00, 8'h00);
      drv(1, 1'b0, 1'b0, 7'h00, 8'h00);
      repeat (3) @(negedge clk);

      chk("rst_ncs", 32'(ncs0), 32'd1);
      chk("rst_sclk", 32'(sclk0), 32'd0);
      chk("rst_copi", 32'(copi0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_ready", 32'(bus0.req_ready), 32'd1);

      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_frame(0, vt[i].w, vt[i].a, vt[i].d, vt[i].fr, 132,
                   $sformatf("vec%0d", i));

      chk("reg0", 32'(preg[0][0]), 32'h A5);
      chk("reg_out_15_8", 32'(preg[0][1]), 32'h3C);
      chk("reg_pwm_7_0", 32'(preg[0][2]), 32'h0F);
      chk("reg_pwm_15_8", 32'(preg[0][3]), 32'hF0);
      chk("reg_duty", 32'(preg[0][4]), 32'h80);
      chk("busy_ready", 32'(busy0), 32'(!bus0.req_ready));

      // Back-to-back: valid held through three frames
      gq0.delete();
      dc = done_cnt[0];
      qs = q0.size();
      drv(0, 1'b1, 1'b1, 7'h02, 8'h5A);
      for (int i = 0; i < 2000 && done_cnt[0] < dc + 3; i++)
         @(negedge clk);
      drv(0, 1'b0, 1'b0, 7'h00, 8'h00);
      if (done_cnt[0] < dc + 3) chk("b2b_timeout", 32'd0, 32'd1);
      repeat (12) @(negedge clk);
      chk("b2b_done", 32'(done_cnt[0] - dc), 32'd3);
      chk("b2b_nfr", 32'(q0.size() - qs), 32'd3);
      if (q0.size() >= qs + 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_frame%0d", i), 32'(q0[qs + i].fr),
                32'h825A);
            chk($sformatf("b2b_low%0d", i), 32'(q0[qs + i].low), 32'd132);
         end
      end
      chk("b2b_ngap", 32'(gq0.size()), 32'd3);
      if (gq0.size() == 3) begin
         chk("b2b_gap1", 32'(gq0[1]), 32'd5);
         chk("b2b_gap2", 32'(gq0[2]), 32'd5);
      end
      chk("ready_in_frame", 32'(rviol[0]), 32'd0);
      chk("reg_b2b", 32'(preg[0][2]), 32'h5A);

      // Reset after the 7th SCLK rise, then a clean frame
      dc = done_cnt[0];
      qs = q0.size();
      r0 = rises[0];
      send_req(0, 1'b1, 7'h03, 8'hC3);
      for (int i = 0; i < 500 && rises[0] < r0 + 7; i++)
         @(negedge clk);
      chk("mid_rises", 32'(rises[0] - r0), 32'd7);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_ncs", 32'(ncs0), 32'd1);
      chk("mid_sclk", 32'(sclk0), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_nodone", 32'(done_cnt[0] - dc), 32'd0);
      chk("mid_nofr", 32'(q0.size() - qs), 32'd0);
      chk("mid_idle", 32'(ncs0), 32'd1);
      chk("mid_reg", 32'(preg[0][3]), 32'hF0);
      run_frame(0, 1'b1, 7'h03, 8'hC3, 16'h83C3, 132, "post_rst");
      chk("post_rst_reg", 32'(preg[0][3]), 32'hC3);

      // Minimum divider, out-of-range address
      run_frame(1, 1'b1, 7'h05, 8'hFF, 16'h85FF, 68, "div2");
      allregs = {preg[1][0], preg[1][1], preg[1][2], preg[1][3]};
      chk("div2_regs03", allregs, 32'h0);
      chk("div2_reg4", 32'(preg[1][4]), 32'h0);

      chk("copi_stable0", 32'(cviol[0]), 32'd0);
      chk("copi_stable1", 32'(cviol[1]), 32'd0);
      chk("ready_in_frame1", 32'(rviol[1]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
